seq_pattern_gen: RTL and testbench



---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_pattern_gen_if.sv | 27 ++
 rtl/seq_bit_shifter.sv | 56 +++++
 rtl/seq_pattern_gen.sv | 171 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the marker-pattern generator and its matching detector.
//   seq_state_e     : generator FSM state encoding (IDLE, SEND, GAP)
//   MARKER_W        : marker pattern length in bits
//   MARKER_PATTERN  : marker pattern, transmitted MSB first
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    localparam int                    MARKER_W       = 6;
    localparam logic [MARKER_W-1:0]   MARKER_PATTERN = 6'b101001;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Serial bit-stream handshake between the pattern generator and its consumer.
//   Stream    : serial data bit
//   bit_valid : Stream holds a bit offered to the consumer
//   bit_ready : consumer accepts the bit (transfer = bit_valid && bit_ready)
//   pat_last  : Stream carries the final bit of a pattern
interface seq_pattern_gen_if;

    logic Stream;
    logic bit_valid;
    logic bit_ready;
    logic pat_last;

    modport master (
        output Stream,
        output bit_valid,
        output pat_last,
        input  bit_ready
    );

    modport slave (
        input  Stream,
        input  bit_valid,
        input  pat_last,
        output bit_ready
    );

endinterface

// File: rtl/seq_bit_shifter.sv
// Pattern shift register for the generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the register (Stream idles low, last flag low)
//   load       : load PATTERN, bit index 0
//   shift      : advance one bit position (one accepted transfer)
//   bit_o      : current bit (register MSB)
//   last_o     : current bit is the final pattern bit
// Priority: clear > load > shift.
module seq_bit_shifter #(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b101001
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic shift,
    output logic bit_o,
    output logic last_o
);

    localparam int IDX_W = $clog2(PAT_W);

    logic [PAT_W-1:0] sh_r;
    logic [IDX_W-1:0] idx_r;
    logic             last_r;

    // Shift register, bit index and last-bit flag; the flag is precomputed so it is a register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r   <= {PAT_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            last_r <= 1'b0;
        end else if (clear) begin
            sh_r   <= {PAT_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            last_r <= 1'b0;
        end else if (load) begin
            sh_r   <= PATTERN;
            idx_r  <= {IDX_W{1'b0}};
            last_r <= 1'b0;
        end else if (shift) begin
            sh_r   <= {sh_r[PAT_W-2:0], 1'b0};
            idx_r  <= idx_r + IDX_W'(1);
            last_r <= (idx_r == IDX_W'(PAT_W - 2));
        end else begin
            sh_r   <= sh_r;
            idx_r  <= idx_r;
            last_r <= last_r;
        end
    end

    assign bit_o  = sh_r[PAT_W-1];
    assign last_o = last_r;

endmodule

// File: rtl/seq_pattern_gen.sv
// Marker-pattern generator: sends rep_n copies of PATTERN (MSB first) separated
// by gap_n zero bits over a valid/ready serial stream, and counts completed patterns.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a burst (ignored while busy)
//   rep_n, gap_n : repetitions / gap bits, sampled when start is accepted
//   abort        : cancel the current burst (wins over start)
//   bus          : Stream / bit_valid / bit_ready / pat_last handshake
//   busy         : burst in progress
//   done         : one-cycle pulse on normal burst completion
//   Counter      : patterns fully transferred, wrapping
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int               PAT_W   = MARKER_W,
    parameter logic [PAT_W-1:0] PATTERN = MARKER_PATTERN,
    parameter int               REP_W   = 8,
    parameter int               GAP_W   = 4,
    parameter int               CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [REP_W-1:0]   rep_n,
    input  logic [GAP_W-1:0]   gap_n,
    input  logic               abort,
    seq_pattern_gen_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   Counter
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_SEND = ST_SEND;
    localparam logic [1:0] S_GAP  = ST_GAP;

    logic [1:0]       state_r,   state_s;
    logic [REP_W-1:0] reps_r,    reps_s;
    logic [GAP_W-1:0] gap_r,     gap_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic [CNT_W-1:0] counter_r, counter_s;
    logic             bit_valid_r;
    logic             busy_r;
    logic             done_r,    done_s;
    logic             sh_load_s, sh_shift_s, sh_clear_s;
    logic             sh_bit_s,  sh_last_s;
    logic             xfer_s;

    assign xfer_s = bit_valid_r & bus.bit_ready;

    seq_bit_shifter #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (sh_clear_s),
        .load   (sh_load_s),
        .shift  (sh_shift_s),
        .bit_o  (sh_bit_s),
        .last_o (sh_last_s)
    );

    // Next-state logic: burst sequencing, rep/gap counting and pattern counting.
    always_comb begin
        state_s    = state_r;
        reps_s     = reps_r;
        gap_s      = gap_r;
        gap_cnt_s  = gap_cnt_r;
        counter_s  = counter_r;
        done_s     = 1'b0;
        sh_load_s  = 1'b0;
        sh_shift_s = 1'b0;
        sh_clear_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    if (rep_n == {REP_W{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        state_s   = S_SEND;
                        reps_s    = rep_n;
                        gap_s     = gap_n;
                        sh_load_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (abort) begin
                    // Partial pattern is dropped without being counted.
                    state_s    = S_IDLE;
                    sh_clear_s = 1'b1;
                end else if (xfer_s) begin
                    if (sh_last_s) begin
                        counter_s = counter_r + CNT_W'(1);
                        reps_s    = reps_r - REP_W'(1);
                        if (reps_r == REP_W'(1)) begin
                            state_s    = S_IDLE;
                            sh_clear_s = 1'b1;
                            done_s     = 1'b1;
                        end else if (gap_r == {GAP_W{1'b0}}) begin
                            // Back-to-back pattern, no bubble.
                            sh_load_s = 1'b1;
                        end else begin
                            // Cleared shifter drives the zero gap bits.
                            state_s    = S_GAP;
                            gap_cnt_s  = gap_r;
                            sh_clear_s = 1'b1;
                        end
                    end else begin
                        sh_shift_s = 1'b1;
                    end
                end else begin
                    state_s = S_SEND;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_s    = S_IDLE;
                    sh_clear_s = 1'b1;
                end else if (xfer_s) begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                    if (gap_cnt_r == GAP_W'(1)) begin
                        state_s   = S_SEND;
                        sh_load_s = 1'b1;
                    end else begin
                        state_s = S_GAP;
                    end
                end else begin
                    state_s = S_GAP;
                end
            end
            default: begin
                state_s    = S_IDLE;
                sh_clear_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            reps_r      <= {REP_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            counter_r   <= {CNT_W{1'b0}};
            bit_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            reps_r      <= reps_s;
            gap_r       <= gap_s;
            gap_cnt_r   <= gap_cnt_s;
            counter_r   <= counter_s;
            bit_valid_r <= (state_s != S_IDLE);
            busy_r      <= (state_s != S_IDLE);
            done_r      <= done_s;
        end
    end

    assign bus.Stream    = sh_bit_s;
    assign bus.pat_last  = sh_last_s;
    assign bus.bit_valid = bit_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign Counter       = counter_r;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed bursts plus random
// rep/gap/ready traffic, checked against an expected-bit queue built from the
// burst parameters.
module tb_seq_pattern_gen;

    localparam logic [5:0] PAT = 6'b101001;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rep_n = 8'd0;
    logic [3:0] gap_n = 4'd0;
    logic       busy;
    logic       done;
    logic [2:0] Counter;

    int checks    = 0;
    int errors    = 0;
    int cnt_model = 0;

    seq_pattern_gen_if bus ();

    seq_pattern_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rep_n   (rep_n),
        .gap_n   (gap_n),
        .abort   (abort),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done),
        .Counter (Counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst: expected bits are built from rep/gap, every transfer pops one.
    task automatic run_burst(input int rep, input int gap, input bit rnd_ready,
                             input int stall_at, input int abort_after, input bit poke_start);
        logic       qb[$];
        logic       ql[$];
        logic [5:0] p = PAT;
        int         xfers = 0;
        int         busy_cycles = 0;
        int         exp_busy;
        int         guard = 0;
        int         stall_left = 3;
        bit         aborted = 1'b0;
        bit         prev_stall = 1'b0;
        logic       prev_s = 1'b0;
        logic       prev_l = 1'b0;
        logic       rdy;
        for (int r = 0; r < rep; r++) begin
            for (int i = 0; i < 6; i++) begin
                qb.push_back(p[5-i]);
                ql.push_back(i == 5);
            end
            if (r < rep - 1) begin
                for (int g = 0; g < gap; g++) begin
                    qb.push_back(1'b0);
                    ql.push_back(1'b0);
                end
            end
        end
        exp_busy = qb.size();
        @(negedge clk);
        start = 1'b1;
        rep_n = 8'(rep);
        gap_n = 4'(gap);
        bus.bit_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (qb.size() > 0 && guard < 400 && !aborted) begin
            guard++;
            chk("bit_valid", 32'(bus.bit_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_in_burst", 32'(done), 32'd0);
            if (prev_stall) begin
                chk("hold_stream", 32'(bus.Stream), 32'(prev_s));
                chk("hold_last", 32'(bus.pat_last), 32'(prev_l));
            end
            busy_cycles++;
            if (abort_after >= 0 && xfers == abort_after) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (xfers == stall_at && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                if (poke_start && xfers == 2) begin
                    start = 1'b1;
                    rep_n = 8'd7;
                    gap_n = 4'd9;
                end else begin
                    start = 1'b0;
                end
                if (rdy) begin
                    chk("stream", 32'(bus.Stream), 32'(qb[0]));
                    chk("pat_last", 32'(bus.pat_last), 32'(ql[0]));
                    if (ql[0]) cnt_model = (cnt_model + 1) % 8;
                    void'(qb.pop_front());
                    void'(ql.pop_front());
                    xfers++;
                end
                prev_stall    = !rdy;
                prev_s        = bus.Stream;
                prev_l        = bus.pat_last;
                bus.bit_ready = rdy;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            abort = 1'b0;
            chk("abort_valid", 32'(bus.bit_valid), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_counter", 32'(Counter), 32'(cnt_model));
            @(negedge clk);
            chk("abort_done_late", 32'(done), 32'd0);
            chk("abort_valid_late", 32'(bus.bit_valid), 32'd0);
        end else begin
            chk("burst_len", 32'(qb.size()), 32'd0);
            chk("done_pulse", 32'(done), 32'd1);
            chk("end_valid", 32'(bus.bit_valid), 32'd0);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_counter", 32'(Counter), 32'(cnt_model));
            if (!rnd_ready && stall_at < 0) chk("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
            @(negedge clk);
            chk("done_single", 32'(done), 32'd0);
        end
    endtask

    initial begin
        bus.bit_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stream", 32'(bus.Stream), 32'd0);
        chk("rst_valid", 32'(bus.bit_valid), 32'd0);
        chk("rst_last", 32'(bus.pat_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_counter", 32'(Counter), 32'd0);
        rst_n = 1'b1;

        // Single pattern, then gapped burst with a start poked while busy.
        run_burst(1, 0, 1'b0, -1, -1, 1'b0);
        run_burst(3, 2, 1'b0, -1, -1, 1'b1);
        // Three-cycle stall on bit 4.
        run_burst(2, 0, 1'b0, 3, -1, 1'b0);
        // Abort on bit 3 of pattern 2.
        run_burst(2, 0, 1'b0, -1, 8, 1'b1);

        // start together with abort in IDLE: nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; rep_n = 8'd1; gap_n = 4'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("startabort_valid", 32'(bus.bit_valid), 32'd0);
        chk("startabort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("startabort_done", 32'(done), 32'd0);

        // Zero repetitions: done only.
        start = 1'b1; rep_n = 8'd0; gap_n = 4'd3;
        @(negedge clk);
        start = 1'b0;
        chk("rep0_done", 32'(done), 32'd1);
        chk("rep0_valid", 32'(bus.bit_valid), 32'd0);
        chk("rep0_busy", 32'(busy), 32'd0);
        chk("rep0_counter", 32'(Counter), 32'(cnt_model));
        @(negedge clk);
        chk("rep0_done_single", 32'(done), 32'd0);
        chk("rep0_valid_late", 32'(bus.bit_valid), 32'd0);

        // Random traffic.
        repeat (6) begin
            run_burst(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1,
                      -1, -1, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a gap.
        @(negedge clk);
        start = 1'b1; rep_n = 8'd2; gap_n = 4'd5; bus.bit_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("gap_valid", 32'(bus.bit_valid), 32'd1);
        chk("gap_stream", 32'(bus.Stream), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stream", 32'(bus.Stream), 32'd0);
        chk("arst_valid", 32'(bus.bit_valid), 32'd0);
        chk("arst_last", 32'(bus.pat_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_counter", 32'(Counter), 32'd0);
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(1, 0, 1'b0, -1, -1, 1'b0);

        // Eight more single-pattern bursts: 9 total wraps the counter to 1.
        repeat (8) run_burst(1, 0, 1'b1, -1, -1, 1'b0);
        chk("counter_wrap", 32'(Counter), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
